// File: rtl/aes512_dout_gearbox_if.sv
// Block-to-word gearbox bus.
//   in_valid/in_data      : 512-bit plaintext blocks from the cipher (no backpressure)
//   out_valid/out_data/
//   out_last/out_ready    : 128-bit word stream, valid/ready handshake
//   almost_full/overflow/
//   level                 : status back to the upstream controller
// The slave modport is the gearbox; the master modport is its environment.
interface aes512_dout_gearbox_if #(
    parameter int DEPTH = 4
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic           in_valid;
    logic [511:0]   in_data;
    logic           out_valid;
    logic [127:0]   out_data;
    logic           out_last;
    logic           out_ready;
    logic           almost_full;
    logic           overflow;
    logic [LW-1:0]  level;

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last, almost_full, overflow, level
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last, almost_full, overflow, level
    );
endinterface

// File: rtl/aes512_dout_gearbox.sv
// Output gearbox for the 512-bit inverse cipher.
// Buffers up to DEPTH plaintext blocks in a circular buffer and streams each
// one out as four 128-bit words, least significant word first.
//   clk  : single rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : slave side of aes512_dout_gearbox_if (block input, word output, status)
module aes512_dout_gearbox #(
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    aes512_dout_gearbox_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(DEPTH - AF_MARGIN);

    logic [511:0]   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]     widx_q, widx_d;
    logic [LW-1:0]  level_q, level_d;
    logic           af_q, af_d;
    logic           ovf_q, ovf_d;

    logic           head_vld;
    logic           word_acc;
    logic           head_free;
    logic           space;
    logic           wr_en;
    logic [511:0]   head_blk;
    logic [127:0]   word_mux;

    always_comb begin
        head_vld  = (level_q != '0);
        word_acc  = head_vld && bus.out_ready;
        head_free = word_acc && (widx_q == 2'd3);
        // A full buffer still takes a block when the head is being retired
        // in the same cycle.
        space     = (level_q < DEPTH_L) || head_free;
        wr_en     = bus.in_valid && space;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        widx_d    = widx_q;

        // widx wraps 3 -> 0 on its own width.
        if (word_acc)  widx_d   = widx_q + 2'd1;
        if (head_free) rd_ptr_d = rd_ptr_q + PW'(1);
        if (wr_en)     wr_ptr_d = wr_ptr_q + PW'(1);

        level_d = level_q + LW'(wr_en) - LW'(head_free);
        af_d    = (level_d >= AF_L);
        ovf_d   = ovf_q | (bus.in_valid && !space);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            widx_q   <= '0;
            level_q  <= '0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            widx_q   <= widx_d;
            level_q  <= level_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    // Block storage carries data only; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem_q[wr_ptr_q] <= bus.in_data;
    end

    // Head word selected combinationally so a block written at edge N is
    // visible during cycle N+1; forced to zero when nothing is stored.
    always_comb begin
        head_blk = mem_q[rd_ptr_q];
        word_mux = '0;
        if (head_vld) begin
            case (widx_q)
                2'd0:    word_mux = head_blk[127:0];
                2'd1:    word_mux = head_blk[255:128];
                2'd2:    word_mux = head_blk[383:256];
                default: word_mux = head_blk[511:384];
            endcase
        end
    end

    assign bus.out_valid   = head_vld;
    assign bus.out_data    = word_mux;
    assign bus.out_last    = head_vld && (widx_q == 2'd3);
    assign bus.level       = level_q;
    assign bus.almost_full = af_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_aes512_dout_gearbox.sv
module tb_aes512_dout_gearbox;
    localparam int DEPTH = 4;
    localparam int AFM   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes512_dout_gearbox_if #(.DEPTH(DEPTH)) bus ();

    aes512_dout_gearbox #(.DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    bit en_chk = 0;

    // Reference model: list of stored blocks, word index of the head, sticky drop flag.
    logic [511:0] mq [$];
    int           mw;
    bit           movf;

    typedef struct {
        logic         iv;
        logic [511:0] d;
        logic         rdy;
        logic         ev;
        logic [127:0] ew;
        logic         el;
        logic [2:0]   elv;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [511:0] rblk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Drive inputs (just after a falling edge), compare outputs with the model,
    // advance one rising edge, update the model, return at the next falling edge.
    task automatic cycle(input logic r, input logic iv, input logic [511:0] d, input logic rdy);
        logic [511:0] hb;
        logic [127:0] ew;
        bit acc, fr, sp;
        rst = r; bus.in_valid = iv; bus.in_data = d; bus.out_ready = rdy;
        #1;
        if (en_chk) begin
            ew = '0;
            if (mq.size() != 0) begin
                hb = mq[0];
                ew = hb[128*mw +: 128];
            end
            chk("out_valid", 128'(bus.out_valid), 128'(mq.size() != 0));
            chk("out_data", bus.out_data, ew);
            chk("out_last", 128'(bus.out_last), 128'(mq.size() != 0 && mw == 3));
            chk("level", 128'(bus.level), 128'(mq.size()));
            chk("almost_full", 128'(bus.almost_full), 128'(mq.size() >= DEPTH - AFM));
            chk("overflow", 128'(bus.overflow), 128'(movf));
        end
        @(posedge clk);
        if (r) begin
            mq.delete(); mw = 0; movf = 0;
        end else begin
            acc = (mq.size() != 0) && rdy;
            fr  = acc && (mw == 3);
            sp  = (mq.size() < DEPTH) || fr;
            if (acc) mw = (mw + 1) % 4;
            if (fr) void'(mq.pop_front());
            if (iv) begin
                if (sp) mq.push_back(d);
                else    movf = 1;
            end
        end
        @(negedge clk);
        en_chk = 1;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [511:0] b0, kb;
        logic [511:0] blks [5];
        logic [127:0] held;

        b0 = {{32{4'h3}}, {32{4'h2}}, {32{4'h1}}, {32{4'h0}}};
        tbl[0] = '{1'b1, b0, 1'b1, 1'b0, 128'h0, 1'b0, 3'd0};
        tbl[1] = '{1'b0, '0, 1'b1, 1'b1, {32{4'h0}}, 1'b0, 3'd1};
        tbl[2] = '{1'b0, '0, 1'b1, 1'b1, {32{4'h1}}, 1'b0, 3'd1};
        tbl[3] = '{1'b0, '0, 1'b1, 1'b1, {32{4'h2}}, 1'b0, 3'd1};
        tbl[4] = '{1'b0, '0, 1'b1, 1'b1, {32{4'h3}}, 1'b1, 3'd1};
        tbl[5] = '{1'b0, '0, 1'b1, 1'b0, 128'h0, 1'b0, 3'd0};

        rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        mw = 0; movf = 0;
        @(negedge clk);
        do_reset();

        // Single block, table driven.
        for (int i = 0; i < 6; i++) begin
            rst = 1'b0; bus.in_valid = tbl[i].iv; bus.in_data = tbl[i].d; bus.out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_valid", i), 128'(bus.out_valid), 128'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i), bus.out_data, tbl[i].ew);
            chk($sformatf("tbl%0d_last", i), 128'(bus.out_last), 128'(tbl[i].el));
            chk($sformatf("tbl%0d_level", i), 128'(bus.level), 128'(tbl[i].elv));
            cycle(1'b0, tbl[i].iv, tbl[i].d, tbl[i].rdy);
        end

        // Known-answer block: decrypted plaintext of zero lands in the low word.
        kb = rblk();
        kb[127:0] = '0;
        cycle(1'b0, 1'b1, kb, 1'b0);
        chk("kat_word0", bus.out_data, 128'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Backpressure after word 1 for 10 cycles.
        b0 = rblk();
        cycle(1'b0, 1'b1, b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        held = bus.out_data;
        chk("bp_word2", held, b0[383:256]);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b0);
            chk("bp_hold", bus.out_data, b0[383:256]);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Fill to DEPTH, drop the fifth, then drain.
        do_reset();
        for (int i = 0; i < 5; i++) blks[i] = rblk();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, blks[i], 1'b0);
            chk("fill_af", 128'(bus.almost_full), 128'(i + 1 >= DEPTH - AFM));
        end
        chk("fill_level", 128'(bus.level), 128'd4);
        cycle(1'b0, 1'b1, blks[4], 1'b0);
        chk("drop_ovf", 128'(bus.overflow), 128'd1);
        chk("drop_level", 128'(bus.level), 128'd4);
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < 4; w++) begin
                chk("drain_word", bus.out_data, blks[i][128*w +: 128]);
                cycle(1'b0, 1'b0, '0, 1'b1);
            end
        end
        chk("drain_empty", 128'(bus.out_valid), 128'd0);

        // Simultaneous free-and-fill at full.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, rblk(), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        chk("simul_last", 128'(bus.out_last), 128'd1);
        cycle(1'b0, 1'b1, blks[0], 1'b1);
        chk("simul_level", 128'(bus.level), 128'd4);
        chk("simul_ovf", 128'(bus.overflow), 128'd0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        chk("simul_empty", 128'(bus.level), 128'd0);

        // Reset mid-stream with two blocks buffered.
        do_reset();
        cycle(1'b0, 1'b1, rblk(), 1'b0);
        cycle(1'b0, 1'b1, rblk(), 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b1, rblk(), 1'b1);
        chk("rst_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_level", 128'(bus.level), 128'd0);
        chk("rst_ovf", 128'(bus.overflow), 128'd0);
        b0 = rblk();
        cycle(1'b0, 1'b1, b0, 1'b0);
        chk("rst_new_word0", bus.out_data, b0[127:0]);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0), rblk(),
                  ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 500; i++) begin
            cycle(1'b0, ($urandom_range(0, 1) == 0), rblk(), ($urandom_range(0, 5) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
